// File: rtl/control_unit.sv
// control_unit: Moore control FSM for the 16-bit RISC core.
// Sequences fetch/decode/execute/memory/write-back plus jump and the AES/I2C
// accelerator triggers. Every output is a register updated with the state,
// so each output always reflects the state currently held.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       decodeComplete,
  input  logic       writeBackComplete,
  output logic       readInstruction,
  output logic       memRead,
  output logic       memWrite,
  output logic       writeBack,
  output logic       aluMode,
  output logic [2:0] op,
  output logic       execute,
  output logic       resetInstructionMemory,
  output logic       resetALU,
  output logic       resetDataMemory,
  output logic       jumpExecute,
  output logic       aes_start,
  output logic       i2c_reset
);

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_JUMP, S_AES, S_I2C
  } state_t;

  localparam logic [3:0] OPC_LD  = 4'b0000;
  localparam logic [3:0] OPC_ST  = 4'b0001;
  localparam logic [3:0] OPC_NOP = 4'b1010;
  localparam logic [3:0] OPC_BEQ = 4'b1011;
  localparam logic [3:0] OPC_BNE = 4'b1100;
  localparam logic [3:0] OPC_JMP = 4'b1101;
  localparam logic [3:0] OPC_AES = 4'b1110;
  localparam logic [3:0] OPC_I2C = 4'b1111;

  state_t     state;
  logic [3:0] opcode_reg;
  // Keeps INIT alive for one clock after reset is released so the
  // sub-block resets are seen with a running clock before the first fetch.
  logic       init_hold;

  // Register ALU class: opcodes 0010..1001 map linearly onto op 000..111.
  function automatic logic is_alu(input logic [3:0] opc);
    return (opc >= 4'd2) && (opc <= 4'd9);
  endfunction

  function automatic logic [2:0] exec_op(input logic [3:0] opc);
    logic [3:0] diff;
    diff = opc - 4'd2;
    if (opc == OPC_BEQ || opc == OPC_BNE)
      return 3'b001;
    else if (is_alu(opc))
      return diff[2:0];
    else
      return 3'b000;
  endfunction

  // State register and all registered outputs; strobes default low each
  // cycle, op/aluMode hold from EXEC until the next FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= S_INIT;
      init_hold              <= 1'b1;
      opcode_reg             <= 4'b0000;
      readInstruction        <= 1'b0;
      memRead                <= 1'b0;
      memWrite               <= 1'b0;
      writeBack              <= 1'b0;
      aluMode                <= 1'b0;
      op                     <= 3'b000;
      execute                <= 1'b0;
      resetInstructionMemory <= 1'b1;
      resetALU               <= 1'b1;
      resetDataMemory        <= 1'b1;
      jumpExecute            <= 1'b0;
      aes_start              <= 1'b0;
      i2c_reset              <= 1'b0;
    end else begin
      readInstruction        <= 1'b0;
      memRead                <= 1'b0;
      memWrite               <= 1'b0;
      writeBack              <= 1'b0;
      execute                <= 1'b0;
      resetInstructionMemory <= 1'b0;
      resetALU               <= 1'b0;
      resetDataMemory        <= 1'b0;
      jumpExecute            <= 1'b0;
      aes_start              <= 1'b0;
      i2c_reset              <= 1'b0;

      case (state)
        S_INIT: begin
          if (init_hold) begin
            init_hold              <= 1'b0;
            resetInstructionMemory <= 1'b1;
            resetALU               <= 1'b1;
            resetDataMemory        <= 1'b1;
          end else begin
            state           <= S_FETCH;
            readInstruction <= 1'b1;
            op              <= 3'b000;
            aluMode         <= 1'b0;
          end
        end

        S_FETCH: begin
          state <= S_DECODE;
        end

        S_DECODE: begin
          if (decodeComplete) begin
            opcode_reg <= opcode;
            case (opcode)
              OPC_JMP: begin
                state       <= S_JUMP;
                jumpExecute <= 1'b1;
              end
              OPC_AES: begin
                state     <= S_AES;
                aes_start <= 1'b1;
              end
              OPC_I2C: begin
                state     <= S_I2C;
                i2c_reset <= 1'b1;
              end
              OPC_NOP: begin
                state           <= S_FETCH;
                readInstruction <= 1'b1;
                op              <= 3'b000;
                aluMode         <= 1'b0;
              end
              default: begin
                state   <= S_EXEC;
                execute <= 1'b1;
                aluMode <= is_alu(opcode);
                op      <= exec_op(opcode);
              end
            endcase
          end
        end

        S_EXEC: begin
          if (opcode_reg == OPC_LD) begin
            state   <= S_MEM;
            memRead <= 1'b1;
          end else if (opcode_reg == OPC_ST) begin
            state    <= S_MEM;
            memWrite <= 1'b1;
          end else if (is_alu(opcode_reg)) begin
            state     <= S_WB;
            writeBack <= 1'b1;
          end else begin
            // Branches: the datapath resolves the PC itself.
            state           <= S_FETCH;
            readInstruction <= 1'b1;
            op              <= 3'b000;
            aluMode         <= 1'b0;
          end
        end

        S_MEM: begin
          if (opcode_reg == OPC_LD) begin
            state     <= S_WB;
            writeBack <= 1'b1;
          end else begin
            state           <= S_FETCH;
            readInstruction <= 1'b1;
            op              <= 3'b000;
            aluMode         <= 1'b0;
          end
        end

        S_WB: begin
          if (writeBackComplete) begin
            state           <= S_FETCH;
            readInstruction <= 1'b1;
            op              <= 3'b000;
            aluMode         <= 1'b0;
          end else begin
            writeBack <= 1'b1;
          end
        end

        S_JUMP, S_AES, S_I2C: begin
          state           <= S_FETCH;
          readInstruction <= 1'b1;
          op              <= 3'b000;
          aluMode         <= 1'b0;
        end

        default: begin
          state           <= S_FETCH;
          readInstruction <= 1'b1;
          op              <= 3'b000;
          aluMode         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit: reset sequencing, ALU/LD/ST flows,
// branch/jump/accelerator flows, NOP, and asynchronous abort from WB.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'b0000;
  logic       decodeComplete = 1'b0;
  logic       writeBackComplete = 1'b0;
  logic       readInstruction, memRead, memWrite, writeBack, aluMode, execute;
  logic [2:0] op;
  logic       resetInstructionMemory, resetALU, resetDataMemory;
  logic       jumpExecute, aes_start, i2c_reset;

  int checks = 0;
  int errors = 0;

  // {readInstruction, memRead, memWrite, execute, jumpExecute, aes_start, i2c_reset}
  logic [6:0] strobes;
  logic [2:0] resets;
  assign strobes = {readInstruction, memRead, memWrite, execute, jumpExecute, aes_start, i2c_reset};
  assign resets  = {resetInstructionMemory, resetALU, resetDataMemory};

  localparam logic [6:0] ST_NONE  = 7'b0000000;
  localparam logic [6:0] ST_FETCH = 7'b1000000;
  localparam logic [6:0] ST_MRD   = 7'b0100000;
  localparam logic [6:0] ST_MWR   = 7'b0010000;
  localparam logic [6:0] ST_EXEC  = 7'b0001000;

  control_unit dut (
    .clk(clk),
    .reset(reset),
    .opcode(opcode),
    .decodeComplete(decodeComplete),
    .writeBackComplete(writeBackComplete),
    .readInstruction(readInstruction),
    .memRead(memRead),
    .memWrite(memWrite),
    .writeBack(writeBack),
    .aluMode(aluMode),
    .op(op),
    .execute(execute),
    .resetInstructionMemory(resetInstructionMemory),
    .resetALU(resetALU),
    .resetDataMemory(resetDataMemory),
    .jumpExecute(jumpExecute),
    .aes_start(aes_start),
    .i2c_reset(i2c_reset)
  );

  always #5 clk = ~clk;

  // Strobe mutual exclusion, checked every cycle.
  always @(negedge clk) begin
    checks++;
    if ($countones(strobes) > 1) begin
      errors++;
      $display("FAIL mutex: strobes=%b, required at most one high", strobes);
    end
  end

  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    step;
    checks++;
    if (resets !== 3'b111 || strobes !== ST_NONE || writeBack !== 1'b0 || op !== 3'b000 || aluMode !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: resets=%b strobes=%b wb=%b op=%b am=%b, required 111 0000000 0 000 0", resets, strobes, writeBack, op, aluMode);
    end
    reset = 1'b0;
    step;
    checks++;
    if (resets !== 3'b111 || strobes !== ST_NONE) begin
      errors++;
      $display("FAIL reset_init_cycle: resets=%b strobes=%b, required 111 0000000", resets, strobes);
    end
    step;
    checks++;
    if (resets !== 3'b000 || strobes !== ST_FETCH) begin
      errors++;
      $display("FAIL reset_first_fetch: resets=%b strobes=%b, required 000 1000000", resets, strobes);
    end
    $display("reset: released, first fetch observed");
  endtask

  // Enters at FETCH; leaves at FETCH.
  task automatic test_alu_wb;
    opcode = 4'b0010;
    decodeComplete = 1'b0;
    step;
    step;
    checks++;
    if (strobes !== ST_NONE) begin
      errors++;
      $display("FAIL decode_wait: strobes=%b, required 0000000", strobes);
    end
    step;
    decodeComplete = 1'b1;
    step;
    decodeComplete = 1'b0;
    checks++;
    if (strobes !== ST_EXEC || aluMode !== 1'b1 || op !== 3'b000) begin
      errors++;
      $display("FAIL add_exec: strobes=%b am=%b op=%b, required 0001000 1 000", strobes, aluMode, op);
    end
    for (int i = 0; i < 3; i++) begin
      step;
      checks++;
      if (writeBack !== 1'b1 || strobes !== ST_NONE) begin
        errors++;
        $display("FAIL add_wb_hold%0d: wb=%b strobes=%b, required 1 0000000", i, writeBack, strobes);
      end
    end
    writeBackComplete = 1'b1;
    step;
    writeBackComplete = 1'b0;
    checks++;
    if (strobes !== ST_FETCH || writeBack !== 1'b0) begin
      errors++;
      $display("FAIL add_refetch: strobes=%b wb=%b, required 1000000 0", strobes, writeBack);
    end
    $display("add: exec 1 cycle, writeBack held 3 cycles, refetch");
  endtask

  // Walks every ALU opcode through EXEC and checks the op encoding.
  task automatic test_alu_ops;
    logic [3:0] opcs [8];
    logic [2:0] exps [8];
    opcs = '{4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001};
    exps = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    for (int i = 0; i < 8; i++) begin
      step;
      opcode = opcs[i];
      decodeComplete = 1'b1;
      step;
      decodeComplete = 1'b0;
      checks++;
      if (strobes !== ST_EXEC || aluMode !== 1'b1 || op !== exps[i]) begin
        errors++;
        $display("FAIL alu_op_%b: strobes=%b am=%b op=%b, required 0001000 1 %b", opcs[i], strobes, aluMode, op, exps[i]);
      end
      step;
      writeBackComplete = 1'b1;
      step;
      writeBackComplete = 1'b0;
      checks++;
      if (strobes !== ST_FETCH) begin
        errors++;
        $display("FAIL alu_refetch_%b: strobes=%b, required 1000000", opcs[i], strobes);
      end
      $display("alu opcode %b: op=%b", opcs[i], op);
    end
  endtask

  task automatic test_load_store;
    step;
    opcode = 4'b0000;
    decodeComplete = 1'b1;
    step;
    decodeComplete = 1'b0;
    checks++;
    if (strobes !== ST_EXEC || aluMode !== 1'b0 || op !== 3'b000) begin
      errors++;
      $display("FAIL ld_exec: strobes=%b am=%b op=%b, required 0001000 0 000", strobes, aluMode, op);
    end
    step;
    checks++;
    if (strobes !== ST_MRD || writeBack !== 1'b0) begin
      errors++;
      $display("FAIL ld_mem: strobes=%b wb=%b, required 0100000 0", strobes, writeBack);
    end
    step;
    writeBackComplete = 1'b1;
    checks++;
    if (strobes !== ST_NONE || writeBack !== 1'b1) begin
      errors++;
      $display("FAIL ld_wb: strobes=%b wb=%b, required 0000000 1", strobes, writeBack);
    end
    step;
    writeBackComplete = 1'b0;
    checks++;
    if (strobes !== ST_FETCH) begin
      errors++;
      $display("FAIL ld_refetch: strobes=%b, required 1000000", strobes);
    end
    $display("ld: exec, memRead, writeBack, refetch");

    step;
    opcode = 4'b0001;
    decodeComplete = 1'b1;
    step;
    decodeComplete = 1'b0;
    checks++;
    if (strobes !== ST_EXEC || aluMode !== 1'b0 || op !== 3'b000) begin
      errors++;
      $display("FAIL st_exec: strobes=%b am=%b op=%b, required 0001000 0 000", strobes, aluMode, op);
    end
    step;
    checks++;
    if (strobes !== ST_MWR || writeBack !== 1'b0) begin
      errors++;
      $display("FAIL st_mem: strobes=%b wb=%b, required 0010000 0", strobes, writeBack);
    end
    step;
    checks++;
    if (strobes !== ST_FETCH || writeBack !== 1'b0) begin
      errors++;
      $display("FAIL st_refetch: strobes=%b wb=%b, required 1000000 0", strobes, writeBack);
    end
    $display("st: exec, memWrite, refetch");
  endtask

  // Branches, jump, accelerators and NOP: one strobe cycle then FETCH.
  task automatic test_branch_accel;
    logic [3:0] opcs [6];
    logic [6:0] exps [6];
    opcs = '{4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b1010};
    exps = '{ST_EXEC, ST_EXEC, 7'b0000100, 7'b0000010, 7'b0000001, ST_FETCH};
    for (int i = 0; i < 6; i++) begin
      step;
      opcode = opcs[i];
      decodeComplete = 1'b1;
      step;
      decodeComplete = 1'b0;
      checks++;
      if (strobes !== exps[i] || writeBack !== 1'b0) begin
        errors++;
        $display("FAIL flow_%b: strobes=%b wb=%b, required %b 0", opcs[i], strobes, writeBack, exps[i]);
      end
      if (exps[i] == ST_EXEC) begin
        checks++;
        if (op !== 3'b001 || aluMode !== 1'b0) begin
          errors++;
          $display("FAIL branch_op_%b: op=%b am=%b, required 001 0", opcs[i], op, aluMode);
        end
      end
      if (exps[i] != ST_FETCH) begin
        step;
        checks++;
        if (strobes !== ST_FETCH) begin
          errors++;
          $display("FAIL flow_refetch_%b: strobes=%b, required 1000000", opcs[i], strobes);
        end
      end
      $display("opcode %b: strobe %b then fetch", opcs[i], exps[i]);
    end
  endtask

  task automatic test_async_reset;
    step;
    opcode = 4'b0010;
    decodeComplete = 1'b1;
    step;
    decodeComplete = 1'b0;
    writeBackComplete = 1'b0;
    step;
    checks++;
    if (writeBack !== 1'b1 || aluMode !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_wb: wb=%b am=%b, required 1 1", writeBack, aluMode);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (writeBack !== 1'b0 || resets !== 3'b111 || strobes !== ST_NONE || op !== 3'b000 || aluMode !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: wb=%b resets=%b strobes=%b op=%b am=%b, required 0 111 0000000 000 0", writeBack, resets, strobes, op, aluMode);
    end
    step;
    step;
    reset = 1'b0;
    step;
    checks++;
    if (resets !== 3'b111 || strobes !== ST_NONE) begin
      errors++;
      $display("FAIL abort_init: resets=%b strobes=%b, required 111 0000000", resets, strobes);
    end
    step;
    checks++;
    if (resets !== 3'b000 || strobes !== ST_FETCH) begin
      errors++;
      $display("FAIL abort_refetch: resets=%b strobes=%b, required 000 1000000", resets, strobes);
    end
    $display("async reset from WB: immediate reset values, fetch after INIT");
  endtask

  initial begin
    test_reset;
    test_alu_wb;
    test_alu_ops;
    test_load_store;
    test_branch_accel;
    test_async_reset;
    step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
